// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers with byte strobes.
// Independent write and read FSMs; all channel outputs are registered.
module axi4_lite_slave_regfile #(
   parameter int unsigned ADDRESS    = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 16
) (
   input  logic                      ACLK,
   input  logic                      ARESETN,
   input  logic [ADDRESS-1:0]        S_AWADDR,
   input  logic                      S_AWVALID,
   output logic                      S_AWREADY,
   input  logic [DATA_WIDTH-1:0]     S_WDATA,
   input  logic [DATA_WIDTH/8-1:0]   S_WSTRB,
   input  logic                      S_WVALID,
   output logic                      S_WREADY,
   output logic [1:0]                S_BRESP,
   output logic                      S_BVALID,
   input  logic                      S_BREADY,
   input  logic [ADDRESS-1:0]        S_ARADDR,
   input  logic                      S_ARVALID,
   output logic                      S_ARREADY,
   output logic [DATA_WIDTH-1:0]     S_RDATA,
   output logic [1:0]                S_RRESP,
   output logic                      S_RVALID,
   input  logic                      S_RREADY
);

   localparam int unsigned IDX_W  = $clog2(NUM_REGS);
   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {WR_IDLE, WR_WAIT_W, WR_WAIT_A, WR_RESP} wr_state_t;
   typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

   function automatic logic in_range(input logic [ADDRESS-1:0] a);
      return a < ADDRESS'(NUM_REGS * 4);
   endfunction

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   wr_state_t             wr_state_q, wr_state_d;
   logic [ADDRESS-1:0]    awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0]     wstrb_q, wstrb_d;
   logic                  awready_q, awready_d, wready_q, wready_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  commit_c;
   logic [ADDRESS-1:0]    commit_addr_c;
   logic [DATA_WIDTH-1:0] commit_data_c;
   logic [STRB_W-1:0]     commit_strb_c;
   logic                  aw_hs_c, w_hs_c;

   rd_state_t             rd_state_q, rd_state_d;
   logic                  arready_q, arready_d;
   logic                  rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic                  ar_hs_c;

   assign aw_hs_c = S_AWVALID && awready_q;
   assign w_hs_c  = S_WVALID && wready_q;
   assign ar_hs_c = S_ARVALID && arready_q;

   // Write FSM: next state, latched halves and commit selection
   always_comb begin
      wr_state_d    = wr_state_q;
      awaddr_d      = awaddr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      bvalid_d      = bvalid_q;
      bresp_d       = bresp_q;
      commit_c      = 1'b0;
      commit_addr_c = S_AWADDR;
      commit_data_c = S_WDATA;
      commit_strb_c = S_WSTRB;
      unique case (wr_state_q)
         WR_IDLE: begin
            if (aw_hs_c && w_hs_c) begin
               commit_c = 1'b1;
            end else if (aw_hs_c) begin
               awaddr_d   = S_AWADDR;
               wr_state_d = WR_WAIT_W;
            end else if (w_hs_c) begin
               wdata_d    = S_WDATA;
               wstrb_d    = S_WSTRB;
               wr_state_d = WR_WAIT_A;
            end
         end
         WR_WAIT_W: begin
            commit_addr_c = awaddr_q;
            commit_c      = w_hs_c;
         end
         WR_WAIT_A: begin
            commit_data_c = wdata_q;
            commit_strb_c = wstrb_q;
            commit_c      = aw_hs_c;
         end
         WR_RESP: begin
            if (S_BREADY) begin
               bvalid_d   = 1'b0;
               wr_state_d = WR_IDLE;
            end
         end
         default: wr_state_d = WR_IDLE;
      endcase
      if (commit_c) begin
         wr_state_d = WR_RESP;
         bvalid_d   = 1'b1;
         bresp_d    = in_range(commit_addr_c) ? RESP_OKAY : RESP_SLVERR;
      end
      awready_d = (wr_state_d == WR_IDLE) || (wr_state_d == WR_WAIT_A);
      wready_d  = (wr_state_d == WR_IDLE) || (wr_state_d == WR_WAIT_W);
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_state_q <= WR_IDLE;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
      end else begin
         wr_state_q <= wr_state_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
      end
   end

   // Register bank with per-byte strobed update
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (commit_c && in_range(commit_addr_c)) begin
         for (int unsigned b = 0; b < STRB_W; b++) begin
            if (commit_strb_c[b])
               regs[commit_addr_c[2 +: IDX_W]][8*b +: 8] <= commit_data_c[8*b +: 8];
         end
      end
   end

   // Read FSM; regs are sampled before any same-cycle commit lands
   always_comb begin
      rd_state_d = rd_state_q;
      rvalid_d   = rvalid_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      unique case (rd_state_q)
         RD_IDLE: begin
            if (ar_hs_c) begin
               rd_state_d = RD_DATA;
               rvalid_d   = 1'b1;
               if (in_range(S_ARADDR)) begin
                  rdata_d = regs[S_ARADDR[2 +: IDX_W]];
                  rresp_d = RESP_OKAY;
               end else begin
                  rdata_d = '0;
                  rresp_d = RESP_SLVERR;
               end
            end
         end
         RD_DATA: begin
            if (S_RREADY) begin
               rvalid_d   = 1'b0;
               rd_state_d = RD_IDLE;
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
      arready_d = (rd_state_d == RD_IDLE);
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rd_state_q <= RD_IDLE;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         rd_state_q <= rd_state_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

   assign S_AWREADY = awready_q;
   assign S_WREADY  = wready_q;
   assign S_BVALID  = bvalid_q;
   assign S_BRESP   = bresp_q;
   assign S_ARREADY = arready_q;
   assign S_RVALID  = rvalid_q;
   assign S_RDATA   = rdata_q;
   assign S_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Directed plus randomized bench for axi4_lite_slave_regfile against an
// array-based register model.
module tb_axi4_lite_slave_regfile;

   localparam int unsigned NREGS = 16;

   logic        ACLK;
   logic        ARESETN;
   logic [31:0] S_AWADDR;
   logic        S_AWVALID;
   logic        S_AWREADY;
   logic [31:0] S_WDATA;
   logic [3:0]  S_WSTRB;
   logic        S_WVALID;
   logic        S_WREADY;
   logic [1:0]  S_BRESP;
   logic        S_BVALID;
   logic        S_BREADY;
   logic [31:0] S_ARADDR;
   logic        S_ARVALID;
   logic        S_ARREADY;
   logic [31:0] S_RDATA;
   logic [1:0]  S_RRESP;
   logic        S_RVALID;
   logic        S_RREADY;

   axi4_lite_slave_regfile #(.ADDRESS(32), .DATA_WIDTH(32), .NUM_REGS(NREGS)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
      .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
      .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
      .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
      .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_fail   = 0;
   logic [31:0] model [NREGS];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   function automatic bit addr_ok(input logic [31:0] a);
      return a < 32'(NREGS * 4);
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      logic [31:0] v;
      v = 32'h0;
      if (addr_ok(a)) v = model[a[2 +: 4]];
      return v;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
   endtask

   // Full write transaction: AW after aw_dly cycles, W after w_dly, B accepted after b_dly.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly);
      bit         aw_done, w_done, aw_fire, w_fire;
      int         cyc;
      logic [1:0] exp_resp;
      aw_done  = 1'b0;
      w_done   = 1'b0;
      cyc      = 0;
      exp_resp = addr_ok(addr) ? 2'b00 : 2'b10;
      while (!(aw_done && w_done) && cyc < 64) begin
         if (!aw_done && cyc >= aw_dly) begin S_AWVALID = 1'b1; S_AWADDR = addr; end
         if (!w_done && cyc >= w_dly) begin
            S_WVALID = 1'b1; S_WDATA = data; S_WSTRB = strb;
         end
         aw_fire = S_AWVALID && S_AWREADY;
         w_fire  = S_WVALID && S_WREADY;
         check("bvalid_before_commit", 32'(S_BVALID), 32'h0);
         tick();
         cyc++;
         if (aw_fire) begin aw_done = 1'b1; S_AWVALID = 1'b0; S_AWADDR = $urandom; end
         if (w_fire) begin
            w_done = 1'b1; S_WVALID = 1'b0; S_WDATA = $urandom; S_WSTRB = 4'($urandom);
         end
      end
      check("write_handshakes", {30'h0, aw_done, w_done}, 32'h3);
      check("bvalid_latency", 32'(S_BVALID), 32'h1);
      check("bresp", 32'(S_BRESP), 32'(exp_resp));
      if (addr_ok(addr)) model[addr[2 +: 4]] = merge(model[addr[2 +: 4]], data, strb);
      for (int i = 0; i < b_dly; i++) begin
         tick();
         check("bvalid_held", 32'(S_BVALID), 32'h1);
         check("bresp_held", 32'(S_BRESP), 32'(exp_resp));
      end
      S_BREADY = 1'b1;
      tick();
      S_BREADY = 1'b0;
      check("bvalid_cleared", 32'(S_BVALID), 32'h0);
      check("wr_readies_back", {30'h0, S_AWREADY, S_WREADY}, 32'h3);
   endtask

   // Full read transaction with r_dly cycles of RREADY backpressure.
   task automatic do_read(input logic [31:0] addr, input int r_dly, output logic [31:0] rd);
      int          cyc;
      logic [31:0] exp_d;
      logic [1:0]  exp_r;
      exp_d = model_read(addr);
      exp_r = addr_ok(addr) ? 2'b00 : 2'b10;
      S_ARVALID = 1'b1;
      S_ARADDR  = addr;
      cyc = 0;
      while (!S_ARREADY && cyc < 64) begin tick(); cyc++; end
      check("arready_seen", 32'(S_ARREADY), 32'h1);
      check("rvalid_before_ar", 32'(S_RVALID), 32'h0);
      tick();
      S_ARVALID = 1'b0;
      S_ARADDR  = $urandom;
      check("rvalid_latency", 32'(S_RVALID), 32'h1);
      check("rdata", S_RDATA, exp_d);
      check("rresp", 32'(S_RRESP), 32'(exp_r));
      rd = S_RDATA;
      for (int i = 0; i < r_dly; i++) begin
         tick();
         check("rvalid_held", 32'(S_RVALID), 32'h1);
         check("rdata_held", S_RDATA, exp_d);
      end
      S_RREADY = 1'b1;
      tick();
      S_RREADY = 1'b0;
      check("rvalid_cleared", 32'(S_RVALID), 32'h0);
      check("arready_back", 32'(S_ARREADY), 32'h1);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] a;
      ARESETN   = 1'b0;
      S_AWADDR  = '0; S_AWVALID = 1'b0;
      S_WDATA   = '0; S_WSTRB   = '0; S_WVALID = 1'b0;
      S_BREADY  = 1'b0;
      S_ARADDR  = '0; S_ARVALID = 1'b0;
      S_RREADY  = 1'b0;
      model_reset();

      // Reset state
      repeat (3) tick();
      check("rst_readies", {29'h0, S_AWREADY, S_WREADY, S_ARREADY}, 32'h0);
      check("rst_valids", {30'h0, S_BVALID, S_RVALID}, 32'h0);
      check("rst_rdata", S_RDATA, 32'h0);
      check("rst_resps", {28'h0, S_BRESP, S_RRESP}, 32'h0);
      ARESETN = 1'b1;
      check("readies_before_edge", {29'h0, S_AWREADY, S_WREADY, S_ARREADY}, 32'h0);
      tick();
      check("readies_after_release", {29'h0, S_AWREADY, S_WREADY, S_ARREADY}, 32'h7);
      for (int i = 0; i < NREGS; i++) do_read(32'(i * 4), 0, rd);

      // Basic write then read, AW one cycle before W
      do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 1, 0);
      do_read(32'h08, 0, rd);
      check("deadbeef", rd, 32'hDEADBEEF);

      // Byte strobes
      do_write(32'h04, 32'h11223344, 4'hF, 0, 0, 0);
      do_write(32'h05, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
      do_read(32'h04, 1, rd);
      check("strobe_merge", rd, 32'h11BB33DD);

      // Out of range
      do_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
      for (int i = 0; i < NREGS; i++) do_read(32'(i * 4), 0, rd);
      do_read(32'h40, 0, rd);
      check("oor_rdata", rd, 32'h0);

      // W first, AW three cycles later, B backpressured
      do_write(32'h1C, 32'h0BADF00D, 4'hF, 3, 0, 5);
      do_read(32'h1C, 2, rd);
      check("w_first_write", rd, 32'h0BADF00D);

      // Same-cycle write and read of one register returns the old value
      do_write(32'h0C, 32'h12, 4'hF, 0, 0, 0);
      S_AWVALID = 1'b1; S_AWADDR = 32'h0C;
      S_WVALID  = 1'b1; S_WDATA  = 32'h55; S_WSTRB = 4'hF;
      S_ARVALID = 1'b1; S_ARADDR = 32'h0C;
      tick();
      S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
      check("simul_bvalid", 32'(S_BVALID), 32'h1);
      check("simul_rvalid", 32'(S_RVALID), 32'h1);
      check("simul_old_value", S_RDATA, 32'h12);
      S_BREADY = 1'b1; S_RREADY = 1'b1;
      tick();
      S_BREADY = 1'b0; S_RREADY = 1'b0;
      model[3] = 32'h55;
      do_read(32'h0C, 0, rd);
      check("simul_new_value", rd, 32'h55);

      // Randomized traffic
      for (int n = 0; n < 60; n++) begin
         a = 32'($urandom_range(0, 32'h4F));
         if ($urandom_range(0, 1) == 0)
            do_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         else
            do_read(a, int'($urandom_range(0, 3)), rd);
      end

      // Reset in the middle of a write
      do_write(32'h10, 32'hCAFEF00D, 4'hF, 0, 0, 0);
      S_AWVALID = 1'b1; S_AWADDR = 32'h10;
      tick();
      S_AWVALID = 1'b0;
      check("aw_only_readies", {30'h0, S_AWREADY, S_WREADY}, 32'h1);
      #2 ARESETN = 1'b0;
      #1;
      check("async_rst_readies", {29'h0, S_AWREADY, S_WREADY, S_ARREADY}, 32'h0);
      check("async_rst_bvalid", 32'(S_BVALID), 32'h0);
      model_reset();
      repeat (2) tick();
      ARESETN = 1'b1;
      tick();
      check("post_rst_readies", {29'h0, S_AWREADY, S_WREADY, S_ARREADY}, 32'h7);
      repeat (3) begin
         tick();
         check("post_rst_no_bvalid", 32'(S_BVALID), 32'h0);
      end
      do_read(32'h10, 0, rd);
      check("post_rst_reg_cleared", rd, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/axi4_lite_slave_regfile.md
# axi4_lite_slave_regfile

AXI4-Lite slave holding a bank of `NUM_REGS` memory-mapped 32-bit registers. It sits directly downstream of the team's AXI4-Lite master and terminates all five channels. Independent write and read FSMs accept addresses and data in either order, apply byte strobes, and return OKAY/SLVERR responses with full backpressure support.

## Interface
- `ADDRESS`, 32, address width
- `DATA_WIDTH`, 32, data width (fixed 32; 4 strobe bits)
- `NUM_REGS`, 16, register count; power of two, 2..256

Ports:
- `ACLK`  in  1  clock, all logic on rising edge
- `ARESETN`  in  1  one clock; reset is asynchronous and active-low
- `S_AWADDR`  in  ADDRESS  write address
- `S_AWVALID`  in  1;  `S_AWREADY`  out  1
- `S_WDATA`  in  DATA_WIDTH;  `S_WSTRB`  in  4;  `S_WVALID`  in  1;  `S_WREADY`  out  1
- `S_BRESP`  out  2;  `S_BVALID`  out  1;  `S_BREADY`  in  1
- `S_ARADDR`  in  ADDRESS;  `S_ARVALID`  in  1;  `S_ARREADY`  out  1
- `S_RDATA`  out  DATA_WIDTH;  `S_RRESP`  out  2;  `S_RVALID`  out  1;  `S_RREADY`  in  1

## Operation
- Decode: index = `addr[2 +: log2(NUM_REGS)]`; `addr[1:0]` ignored; address >= `NUM_REGS*4` is out of range.
- Write FSM states:
  - WR_IDLE: AWREADY=1, WREADY=1.
    - AW only → latch addr → WR_WAIT_W.
    - W only → latch data/strb → WR_WAIT_A.
    - Both in the same cycle → commit → WR_RESP.
  - WR_WAIT_W: AWREADY=0, WREADY=1; W handshake → commit → WR_RESP.
  - WR_WAIT_A: AWREADY=1, WREADY=0; AW handshake → commit → WR_RESP.
  - WR_RESP: BVALID=1 and BRESP held stable; BVALID&&BREADY → WR_IDLE.
- Commit:
  - In range: byte k of reg[index] ← WDATA byte k where WSTRB[k]=1. BRESP=2'b00.
  - Out of range: no register changes. BRESP=2'b10 (SLVERR).
- Read FSM states:
  - RD_IDLE: ARREADY=1; AR handshake → register RDATA/RRESP → RD_DATA.
  - RD_DATA: RVALID=1 and RDATA/RRESP held stable; RVALID&&RREADY → RD_IDLE.
- Read response:
  - In range: RDATA=reg[index], RRESP=2'b00.
  - Out of range: RDATA=0, RRESP=2'b10.
- The read and write FSMs are fully independent.
- Write commit and AR handshake to the same register in the same cycle: the read returns the pre-write value.

## Timing
- Reset (asynchronous, while ARESETN=0):
  - All registers and both FSMs clear (FSMs to *_IDLE).
  - BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0.
  - AWREADY, WREADY, ARREADY are forced 0 while ARESETN=0 and go to 1 in the first cycle after release.
- Write latency:
  - AW and W handshake in cycle N: register updated at the end of N, BVALID=1 in N+1.
  - With the team's master (AW in N, W in N+1 or later), BVALID rises the cycle after the W handshake.
- Read latency: AR handshake in cycle N → RVALID=1 in N+1; minimum 2 cycles per read.
- Throughput: one outstanding write and one outstanding read. No new AW/W is accepted until B completes; no new AR until R completes.
- Backpressure: BVALID/RVALID remain asserted with stable payload for any number of cycles BREADY/RREADY stays low.
- Back-to-back:
  - B handshake in cycle M → AWREADY/WREADY=1 in M+1.
  - R handshake in cycle M → ARREADY=1 in M+1.
- Reset mid-transaction aborts it. A pending write that has not committed is dropped. Outputs take reset values immediately (asynchronously).

## Test plan
- Reset: during and after ARESETN low, B/RVALID=0 and readies=0 then 1; reading addresses 0x00..0x3C returns 0 with RRESP=00.
- Write 0xDEADBEEF to 0x08 (AW then W next cycle, BREADY held high) → BVALID one cycle after W, BRESP=00; read 0x08 → RDATA=0xDEADBEEF, RVALID one cycle after AR.
- Strobe: reg 0x04=0x11223344; write 0xAABBCCDD with WSTRB=4'b0101 → read 0x04 returns 0x11BB33DD.
- Out of range: write 0x40 with data 0xFFFFFFFF → BRESP=10 and no register changes; read 0x40 → RDATA=0, RRESP=10.
- Ordering/backpressure: W at cycle 0, AW at cycle 3; BREADY low 5 cycles → BVALID held with BRESP=00, write takes effect. Simultaneous write of 0x55 and read of the same reg (old value 0x12) → RDATA=0x12.
- Reset mid-write: AW accepted, ARESETN pulsed low before W → no BVALID, readies drop, target reg reads 0 afterwards.
